// File: rtl/turn_signal_sched_pkg.sv
// Shared types and constants for the tail-lamp request scheduler.
// Counter widths are derived from the divider/debounce lengths via cnt_width().
package turn_signal_sched_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LEFT_RUN  = 2'd1,
        RIGHT_RUN = 2'd2,
        HAZ_RUN   = 2'd3
    } state_e;

    localparam logic [1:0] LAST_TURN_STEP = 2'd2;

    localparam int TICK_DIV_DEFAULT   = 12_500_000;
    localparam int DEB_CYCLES_DEFAULT = 1_000_000;

    // Bits needed to count 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int TCNT_W_DEFAULT = cnt_width(TICK_DIV_DEFAULT);
    localparam int DCNT_W_DEFAULT = cnt_width(DEB_CYCLES_DEFAULT);

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser followed by a counting debouncer: the debounced
// level follows the input only after it has differed for DEB_CYCLES cycles.
module sw_debounce
    import turn_signal_sched_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic sw,
    output logic deb
);

    localparam int              CW       = cnt_width(DEB_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          deb_q;
    logic          deb_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (cnt_q == CNT_LAST) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sw;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign deb = deb_q;

endmodule

// File: rtl/turn_signal_sched.sv
// Thunderbird tail-lamp request scheduler: debounced switches, free-running
// step tick, and a tick-paced arbiter with hazard pre-emption and L/R round-robin.
module turn_signal_sched
    import turn_signal_sched_pkg::*;
#(
    parameter int TICK_DIV   = TICK_DIV_DEFAULT,
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sw_left,
    input  logic       sw_right,
    input  logic       sw_haz,
    output logic       tick,
    output logic       req_left,
    output logic       req_right,
    output logic       req_haz,
    output logic [1:0] step,
    output logic       busy,
    output logic       abort
);

    localparam int            TW        = cnt_width(TICK_DIV);
    localparam logic [TW-1:0] TCNT_LAST = TW'(TICK_DIV - 1);

    // Index 0 = left, 1 = right, 2 = hazard.
    logic [2:0] sw_raw;
    logic [2:0] sw_deb;

    assign sw_raw = {sw_haz, sw_right, sw_left};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_deb
            sw_debounce #(
                .DEB_CYCLES(DEB_CYCLES)
            ) u_deb (
                .clk  (clk),
                .reset(reset),
                .sw   (sw_raw[gi]),
                .deb  (sw_deb[gi])
            );
        end
    endgenerate

    logic          d_left;
    logic          d_right;
    logic          d_haz;

    assign d_left  = sw_deb[0];
    assign d_right = sw_deb[1];
    assign d_haz   = sw_deb[2];

    logic [TW-1:0] tcnt_q;
    logic [TW-1:0] tcnt_d;
    logic          tick_q;
    logic          tick_d;
    state_e        state_q;
    state_e        state_d;
    logic [1:0]    step_q;
    logic [1:0]    step_d;
    logic          rr_left_q;
    logic          rr_left_d;
    logic          abort_q;
    logic          abort_d;

    always_comb begin
        tick_d = (tcnt_q == TCNT_LAST);
        tcnt_d = tick_d ? '0 : tcnt_q + TW'(1);
    end

    // All transitions are paced by the registered tick; every state entry restarts step at 0.
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        rr_left_d = rr_left_q;
        abort_d   = 1'b0;
        if (tick_q) begin
            case (state_q)
                IDLE: begin
                    step_d = 2'd0;
                    if (d_haz) begin
                        state_d = HAZ_RUN;
                    end else if (d_left && (!d_right || rr_left_q)) begin
                        state_d   = LEFT_RUN;
                        rr_left_d = 1'b0;
                    end else if (d_right) begin
                        state_d   = RIGHT_RUN;
                        rr_left_d = 1'b1;
                    end
                end
                LEFT_RUN, RIGHT_RUN: begin
                    if (d_haz) begin
                        state_d = HAZ_RUN;
                        step_d  = 2'd0;
                        abort_d = 1'b1;
                    end else if (step_q == LAST_TURN_STEP) begin
                        state_d = IDLE;
                        step_d  = 2'd0;
                    end else begin
                        step_d = step_q + 2'd1;
                    end
                end
                HAZ_RUN: begin
                    state_d = IDLE;
                    step_d  = 2'd0;
                end
                default: begin
                    state_d = IDLE;
                    step_d  = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt_q    <= '0;
            tick_q    <= 1'b0;
            state_q   <= IDLE;
            step_q    <= 2'd0;
            rr_left_q <= 1'b1;
            abort_q   <= 1'b0;
        end else begin
            tcnt_q    <= tcnt_d;
            tick_q    <= tick_d;
            state_q   <= state_d;
            step_q    <= step_d;
            rr_left_q <= rr_left_d;
            abort_q   <= abort_d;
        end
    end

    assign tick      = tick_q;
    assign req_left  = (state_q == LEFT_RUN);
    assign req_right = (state_q == RIGHT_RUN);
    assign req_haz   = (state_q == HAZ_RUN);
    assign step      = step_q;
    assign busy      = (state_q != IDLE);
    assign abort     = abort_q;

endmodule
